// File: rtl/mem_arbiter_if.sv
// Pipeline-side and RAM-side signals of the shared-memory arbiter, grouped for port passing.
// master is the pipeline + RAM environment, slave is the arbiter itself.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic        datomic;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport master (
        output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data memory, data-first with a
// bounded fetch starvation count, and the LL/SC link register resolved at the memory boundary.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, IFETCH, DACCESS, SCFAIL} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      r_state;
    logic [3:0]  r_starve;
    logic        r_link_valid;
    logic [31:0] r_link_addr;
    logic        r_ren;
    logic        r_wen;
    logic        r_atomic;
    logic [31:0] r_addr;
    logic [31:0] r_store;

    logic        w_dreq;
    logic        w_dwin;
    logic        w_sc_req;
    logic        w_sc_ok;
    logic        w_access;
    logic [31:0] w_dload;

    assign w_dreq   = bus.dREN | bus.dWEN;
    assign w_dwin   = w_dreq && ((r_starve < STARVE_LIM) || !bus.iREN);
    assign w_sc_req = bus.dWEN & bus.datomic;
    assign w_sc_ok  = r_link_valid && (r_link_addr == bus.daddr);
    assign w_access = (bus.ramstate == RAM_ACCESS);

    // Control: grant decision, enables, starvation count and link register.
    // Only ACCESS lets a grant state finish; BUSY/FREE/ERROR hold everything as is.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_starve     <= '0;
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
            r_ren        <= 1'b0;
            r_wen        <= 1'b0;
            r_atomic     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!bus.iREN)
                        r_starve <= '0;
                    if (w_dwin) begin
                        if (bus.iREN && (r_starve < STARVE_LIM))
                            r_starve <= r_starve + 4'd1;
                        r_atomic <= bus.datomic;
                        if (w_sc_req && !w_sc_ok) begin
                            r_state <= SCFAIL;
                        end else begin
                            r_state <= DACCESS;
                            r_ren   <= bus.dREN;
                            r_wen   <= bus.dWEN;
                        end
                    end else if (bus.iREN) begin
                        r_state  <= IFETCH;
                        r_ren    <= 1'b1;
                        r_wen    <= 1'b0;
                        r_atomic <= 1'b0;
                        r_starve <= '0;
                    end
                end
                IFETCH: begin
                    if (w_access) begin
                        r_state <= IDLE;
                        r_ren   <= 1'b0;
                    end
                end
                DACCESS: begin
                    if (w_access) begin
                        r_state <= IDLE;
                        r_ren   <= 1'b0;
                        r_wen   <= 1'b0;
                        // SC or a store to the linked word kills the link; the clear wins over an LL set.
                        if (r_wen && (r_atomic || (r_addr == r_link_addr))) begin
                            r_link_valid <= 1'b0;
                        end else if (r_ren && r_atomic) begin
                            r_link_valid <= 1'b1;
                            r_link_addr  <= r_addr;
                        end
                    end
                end
                SCFAIL: begin
                    r_state      <= IDLE;
                    r_link_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Grant latch: address and write data captured on leaving IDLE.
    always_ff @(posedge CLK) begin
        if (r_state == IDLE) begin
            if (w_dwin) begin
                r_addr  <= bus.daddr;
                r_store <= bus.dstore;
            end else if (bus.iREN) begin
                r_addr  <= bus.iaddr;
            end
        end
    end

    always_comb begin
        w_dload = '0;
        if (r_state == DACCESS) begin
            if (r_ren)
                w_dload = bus.ramload;
            else if (r_atomic)
                w_dload = 32'd1;
        end
    end

    assign bus.ramREN   = r_ren;
    assign bus.ramWEN   = r_wen;
    assign bus.ramaddr  = ((r_state == IFETCH) || (r_state == DACCESS)) ? r_addr : '0;
    assign bus.ramstore = (r_state == DACCESS) ? r_store : '0;
    assign bus.ihit     = (r_state == IFETCH) && w_access;
    assign bus.iload    = bus.ihit ? bus.ramload : '0;
    assign bus.dhit     = ((r_state == DACCESS) && w_access) || (r_state == SCFAIL);
    assign bus.dload    = w_dload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized traffic against a
// transaction-level memory/link model and a starvation-bound tracker.
module tb_mem_arbiter;
    localparam int SM = 2;
    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;
    localparam int OP_NONE = -1, OP_LW = 0, OP_SW = 1, OP_LL = 2, OP_SC = 3;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] ram_mem [256];
    logic [31:0] ref_mem [256];
    logic        ref_lv;
    logic [31:0] ref_la;
    logic [1:0]  ram_q [$];
    bit          ram_rnd = 1'b0;
    int          last_lat;
    bit          last_traffic;
    logic [31:0] last_dload;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    // One clock: RAM answers at the falling edge, outputs sampled 1 ns later,
    // and a write accepted this cycle lands in the RAM array.
    task automatic step();
        @(negedge clk);
        if (bus.ramREN || bus.ramWEN) begin
            if (ram_q.size() > 0) bus.ramstate = ram_q.pop_front();
            else if (ram_rnd) begin
                case ($urandom_range(3))
                    0, 1:    bus.ramstate = RS_ACCESS;
                    2:       bus.ramstate = RS_BUSY;
                    default: bus.ramstate = RS_ERROR;
                endcase
            end else bus.ramstate = RS_ACCESS;
        end else bus.ramstate = RS_FREE;
        bus.ramload = ram_mem[bus.ramaddr[9:2]];
        #1;
        if (bus.ramWEN && bus.ramstate == RS_ACCESS) ram_mem[bus.ramaddr[9:2]] = bus.ramstore;
    endtask

    // Architectural effect of one completed data op on memory and the link.
    task automatic model_data(input int op, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] r);
        r = '0;
        case (op)
            OP_LW: r = ref_mem[a[9:2]];
            OP_LL: begin r = ref_mem[a[9:2]]; ref_lv = 1'b1; ref_la = a; end
            OP_SW: begin ref_mem[a[9:2]] = d; if (a == ref_la) ref_lv = 1'b0; end
            default: begin
                if (ref_lv && ref_la == a) begin ref_mem[a[9:2]] = d; r = 32'd1; end
                ref_lv = 1'b0;
            end
        endcase
    endtask

    task automatic set_d(input int op, input logic [31:0] a, input logic [31:0] d);
        bus.dREN    = (op == OP_LW) || (op == OP_LL);
        bus.dWEN    = (op == OP_SW) || (op == OP_SC);
        bus.datomic = (op == OP_LL) || (op == OP_SC);
        bus.daddr   = a;
        bus.dstore  = d;
    endtask

    task automatic dtxn(input int op, input logic [31:0] a, input logic [31:0] d, input string tag);
        logic [31:0] e;
        logic [31:0] got = '0;
        int lat = 0;
        bit wen = 1'b0, traffic = 1'b0, hit = 1'b0;
        set_d(op, a, d);
        while (!hit && lat < 40) begin
            step();
            lat++;
            if (bus.ramWEN) wen = 1'b1;
            if (bus.ramREN || bus.ramWEN) traffic = 1'b1;
            hit = bus.dhit;
            if (hit) begin
                got = bus.dload;
                if (bus.ramREN || bus.ramWEN) chk({tag, "_addr"}, bus.ramaddr, a);
                if (bus.ramWEN) chk({tag, "_store"}, bus.ramstore, d);
            end
        end
        set_d(OP_NONE, '0, '0);
        model_data(op, a, d, e);
        chk({tag, "_hit"}, 32'(hit), 32'd1);
        chk({tag, "_dload"}, got, e);
        if (op == OP_SW || op == OP_SC)
            chk({tag, "_wen"}, 32'(wen), 32'((op == OP_SW) || (e == 32'd1)));
        last_lat = lat;
        last_traffic = traffic;
        last_dload = got;
        step();
        chk({tag, "_1cyc"}, 32'(bus.dhit), 32'd0);
    endtask

    initial begin
        logic [31:0] e;
        int en, hits;
        rst = 1'b1;
        bus.iREN = 1'b0; bus.iaddr = '0;
        set_d(OP_NONE, '0, '0);
        bus.ramstate = RS_FREE; bus.ramload = '0;
        for (int i = 0; i < 256; i++) begin ram_mem[i] = $urandom; ref_mem[i] = ram_mem[i]; end
        ram_mem[16] = 32'h8C220004; ref_mem[16] = 32'h8C220004;
        ref_lv = 1'b0; ref_la = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ren", 32'(bus.ramREN), 0); chk("rst_wen", 32'(bus.ramWEN), 0);
        chk("rst_ihit", 32'(bus.ihit), 0);  chk("rst_dhit", 32'(bus.dhit), 0);
        chk("rst_addr", bus.ramaddr, 0);
        rst = 1'b0;

        // Lone fetch, zero-wait RAM
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        step();
        chk("lf_ren", 32'(bus.ramREN), 1); chk("lf_addr", bus.ramaddr, 32'h40);
        chk("lf_ihit", 32'(bus.ihit), 1);  chk("lf_iload", bus.iload, 32'h8C220004);
        bus.iREN = 1'b0;
        step();
        chk("lf_idle_ren", 32'(bus.ramREN), 0); chk("lf_1cyc", 32'(bus.ihit), 0);

        // Simultaneous requests: data first, fetch in the third cycle
        bus.iREN = 1'b1; bus.iaddr = 32'h44; set_d(OP_LW, 32'h100, '0);
        step();
        chk("sim_dhit", 32'(bus.dhit), 1); chk("sim_ihit0", 32'(bus.ihit), 0);
        chk("sim_addr", bus.ramaddr, 32'h100);
        model_data(OP_LW, 32'h100, '0, e);
        chk("sim_dload", bus.dload, e);
        set_d(OP_NONE, '0, '0);
        step();
        chk("sim_gap_ihit", 32'(bus.ihit), 0); chk("sim_gap_ren", 32'(bus.ramREN), 0);
        step();
        chk("sim_ihit", 32'(bus.ihit), 1); chk("sim_iload", bus.iload, ref_mem[17]);
        bus.iREN = 1'b0;
        step();

        // Starvation bound: fetch forced after SM consecutive data grants
        bus.iREN = 1'b1; bus.iaddr = 32'h80; set_d(OP_LW, 32'h120, '0);
        begin
            int cnt = 0, g = 0, cyc = 0;
            while (g < 6 && cyc < 40) begin
                step();
                cyc++;
                if (bus.dhit || bus.ihit) begin
                    chk("stv_order", 32'(bus.dhit), 32'(cnt < SM));
                    if (bus.dhit) chk("stv_dload", bus.dload, ref_mem[8'h48]);
                    else chk("stv_iload", bus.iload, ref_mem[8'h20]);
                    if (cnt < SM) cnt++; else cnt = 0;
                    g++;
                end
            end
            chk("stv_grants", g, 6);
        end
        bus.iREN = 1'b0; set_d(OP_NONE, '0, '0);
        step(); step();

        // LL/SC basic
        dtxn(OP_LL, 32'h200, '0, "ll1");
        dtxn(OP_SC, 32'h200, 32'h5, "sc1");
        chk("sc1_ok", last_dload, 32'd1);
        dtxn(OP_SC, 32'h200, 32'h6, "sc2");
        chk("sc2_fail", last_dload, 32'd0);
        chk("sc2_lat", last_lat, 1);
        chk("sc2_traffic", 32'(last_traffic), 0);
        dtxn(OP_LW, 32'h200, '0, "rd1");
        chk("rd1_val", last_dload, 32'h5);

        // Link invalidation by a store to the linked word, and not by a neighbour
        dtxn(OP_LL, 32'h200, '0, "ll2");
        dtxn(OP_SW, 32'h200, 32'h11, "sw2");
        dtxn(OP_SC, 32'h200, 32'h22, "sc3");
        chk("sc3_fail", last_dload, 32'd0);
        dtxn(OP_LW, 32'h200, '0, "rd2");
        chk("rd2_val", last_dload, 32'h11);
        dtxn(OP_LL, 32'h200, '0, "ll3");
        dtxn(OP_SW, 32'h204, 32'h33, "sw3");
        dtxn(OP_SC, 32'h200, 32'h44, "sc4");
        chk("sc4_ok", last_dload, 32'd1);
        dtxn(OP_LW, 32'h200, '0, "rd3");
        chk("rd3_val", last_dload, 32'h44);

        // ERROR retries: three ERROR cycles then ACCESS
        repeat (3) ram_q.push_back(RS_ERROR);
        set_d(OP_SW, 32'h300, 32'hA5A50001);
        en = 0; hits = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.ramWEN) en++;
            if (bus.dhit) begin hits++; set_d(OP_NONE, '0, '0); end
        end
        model_data(OP_SW, 32'h300, 32'hA5A50001, e);
        chk("err_en_cycles", en, 4);
        chk("err_hits", hits, 1);
        dtxn(OP_LW, 32'h300, '0, "err_rd");

        // Reset in the middle of a BUSY data access
        dtxn(OP_LL, 32'h240, '0, "rs_ll");
        repeat (20) ram_q.push_back(RS_BUSY);
        set_d(OP_LW, 32'h100, '0);
        step(); step();
        chk("rs_busy_ren", 32'(bus.ramREN), 1); chk("rs_busy_dhit", 32'(bus.dhit), 0);
        #2 rst = 1'b1;
        #1;
        chk("rs_ren", 32'(bus.ramREN), 0); chk("rs_wen", 32'(bus.ramWEN), 0);
        chk("rs_dhit", 32'(bus.dhit), 0);  chk("rs_ihit", 32'(bus.ihit), 0);
        chk("rs_addr", bus.ramaddr, 0);
        set_d(OP_NONE, '0, '0);
        ram_q.delete();
        ref_lv = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rs_idle_ren", 32'(bus.ramREN), 0);
        dtxn(OP_SC, 32'h240, 32'h7, "rs_sc");
        chk("rs_sc_fail", last_dload, 32'd0);
        chk("rs_sc_lat", last_lat, 1);
        chk("rs_sc_traffic", 32'(last_traffic), 0);

        // Randomized concurrent traffic with a stalling/erroring RAM
        ram_rnd = 1'b1;
        begin
            bit f_act = 1'b0, d_act = 1'b0, d_fidv = 1'b0, d_wen = 1'b0;
            int f_age = 0, d_age = 0, f_id = 0, d_fid = 0, streak = 0, d_op = 0;
            logic [31:0] f_addr = '0, d_a = '0, d_d = '0;
            for (int c = 0; c < 3000; c++) begin
                step();
                chk("r_excl", 32'(bus.ihit & bus.dhit), 0);
                if (bus.ramWEN) d_wen = 1'b1;
                if (bus.ihit) begin
                    if (f_act) begin
                        chk("r_iload", bus.iload, ref_mem[f_addr[9:2]]);
                        chk("r_iaddr", bus.ramaddr, f_addr);
                        f_act = 1'b0; bus.iREN = 1'b0; streak = 0;
                    end else chk("r_ispur", 32'(bus.ihit), 0);
                end else if (f_act) begin
                    f_age++;
                    if (f_age > 100) begin chk("r_itimeout", 0, 1); f_act = 1'b0; bus.iREN = 1'b0; end
                end
                if (bus.dhit) begin
                    if (d_act) begin
                        model_data(d_op, d_a, d_d, e);
                        chk("r_dload", bus.dload, e);
                        if (d_op == OP_SW || d_op == OP_SC)
                            chk("r_dwen", 32'(d_wen), 32'((d_op == OP_SW) || (e == 32'd1)));
                        if (d_fidv && f_act && d_fid == f_id) begin
                            streak++;
                            chk("r_starve", 32'(streak <= SM), 1);
                        end
                        d_act = 1'b0; set_d(OP_NONE, '0, '0);
                    end else chk("r_dspur", 32'(bus.dhit), 0);
                end else if (d_act) begin
                    d_age++;
                    if (d_age > 100) begin chk("r_dtimeout", 0, 1); d_act = 1'b0; set_d(OP_NONE, '0, '0); end
                end
                if (!f_act && $urandom_range(3) == 0) begin
                    f_act = 1'b1; f_age = 0; f_id++; streak = 0;
                    f_addr = 32'($urandom_range(255)) << 2;
                    bus.iREN = 1'b1; bus.iaddr = f_addr;
                end
                if (!d_act && $urandom_range(2) == 0) begin
                    d_op = int'($urandom_range(3));
                    d_a = 32'h200 + (32'($urandom_range(3)) << 2);
                    d_d = $urandom;
                    d_act = 1'b1; d_age = 0; d_wen = 1'b0;
                    d_fidv = f_act; d_fid = f_id;
                    set_d(d_op, d_a, d_d);
                end
            end
        end
        bus.iREN = 1'b0; set_d(OP_NONE, '0, '0);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing the single-ported RAM between the pipeline's instruction-fetch port and data-memory port. It grants one requester at a time with data priority and a starvation bound for fetch, returns one-cycle hit strobes that the pipeline uses as stall release, and implements the LL/SC link register so SC success or failure is resolved at the memory boundary.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is pending before fetch is forced; range 1-15.
- CLK  in  1  pipeline clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  fetch request; held until ihit.
- iaddr  in  32  fetch word address.
- ihit  out  1  fetch complete; iload valid this cycle.
- iload  out  32  fetched instruction.
- dREN  in  1  data read request (LW, or LL when datomic).
- dWEN  in  1  data write request (SW, or SC when datomic); dREN and dWEN are never both high.
- datomic  in  1  qualifies dREN as LL and dWEN as SC.
- daddr  in  32  data word address.
- dstore  in  32  write data.
- dhit  out  1  data complete; dload valid this cycle.
- dload  out  32  read data; for SC, 1 = success, 0 = fail.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

## Operation
- States: IDLE, IFETCH, DACCESS, SCFAIL. Reset: IDLE, starve_cnt 0, link_valid 0, link_addr 0.
- Grant latch: on leaving IDLE, the granted port's address, write data and op are registered. RAM outputs are driven only from these latched values.
- IDLE decision, evaluated each cycle:
  - A data request is pending and either starve_cnt < STARVE_MAX or iREN = 0.
    - If the request is an SC and link_valid = 0 or link_addr != daddr, go to SCFAIL.
    - Otherwise go to DACCESS.
  - Otherwise, if iREN = 1, go to IFETCH.
  - Otherwise stay in IDLE.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each DACCESS or SCFAIL entry while iREN = 1.
  - Clears on IFETCH entry.
  - Clears in IDLE when iREN = 0.
- IFETCH:
  - Drive ramREN = 1 and ramaddr = latched iaddr.
  - When ramstate = ACCESS: ihit = 1 and iload = ramload combinationally that cycle, then go to IDLE.
- DACCESS:
  - Drive ramREN or ramWEN per the latched op, ramaddr = latched daddr, ramstore = latched dstore.
  - When ramstate = ACCESS: dhit = 1, then go to IDLE.
  - dload = ramload for reads, 1 for SC, 0 for plain SW.
- SCFAIL: no RAM enables; dhit = 1 and dload = 0 for one cycle, then go to IDLE.
- ERROR: the arbiter stays in the same state and keeps the enables asserted, so the RAM retries the access; no hit is produced.
- BUSY/FREE: hold all RAM outputs stable.
- Link register updates, all at the completing edge:
  - LL completion sets link_valid = 1 and link_addr = daddr.
  - Any SC resolution, success or SCFAIL, clears link_valid.
  - A plain SW completing with addr = link_addr clears link_valid.
  - Same-edge priority: clear beats set (cannot coincide by construction, but the clear wins).
- Withdrawn request: if a requester deasserts after grant, the latched transaction still completes and the hit still pulses. The pipeline ignores a hit it no longer wants.
- All outputs not listed as driven in the current state are 0.

## Timing
- Decision is registered. A request visible in IDLE at cycle N enters its grant state at edge N+1.
- RAM enables are high from cycle N+1. The hit is combinational on ramstate in the grant state.
- Minimum latency with a zero-wait RAM (ACCESS in the first grant cycle): request in cycle N, hit in cycle N+1.
- SC fail latency: hit in cycle N+1, with no RAM traffic.
- At least one IDLE cycle separates consecutive grants.
- Every hit is exactly one cycle wide.
- RST asserted mid-access drops ramREN, ramWEN, ihit and dhit within the same cycle (asynchronous). The in-flight transaction is abandoned; link_valid = 0 and starve_cnt = 0.

## Test plan
- **Lone fetch.** iREN=1, iaddr=0x40, RAM returns ACCESS on the first cycle with ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 next cycle; ihit=1 and iload=0x8C220004 that same cycle; back to IDLE.
- **Simultaneous requests.** iREN and dREN high in the same cycle, daddr=0x100 -> DACCESS is granted first (dhit), then IFETCH; ihit comes no earlier than the third cycle.
- **Starvation bound.** STARVE_MAX=2, iREN held high, with back-to-back data requests -> grant order is D, D, I, D, D, I; starve_cnt never exceeds 2.
- **LL/SC.** LL 0x200, then SC 0x200 with dstore=0x5 -> ramWEN=1, ramstore=0x5, dload=1. A second SC to 0x200 -> SCFAIL: dload=0, no ramWEN.
- **Link invalidation.** LL 0x200, then plain SW 0x200, then SC 0x200 -> the SC fails (dload=0) with no RAM write. A variant with the SW to 0x204 instead -> the SC succeeds.
- **Error and reset.**
  - ramstate=ERROR for 3 cycles, then ACCESS -> enables held for 4 cycles and exactly one dhit.
  - RST pulse during a BUSY DACCESS -> all outputs 0 immediately; after release, state is IDLE and a pending SC fails.
